// File: rtl/muldiv.sv
// Iterative MIPS-style HI/LO multiply/divide unit; busy stalls the pipe, done pulses once per result.
// Latency 32 RUN cycles (result at t0+33); with MULDIV_FAST_MULT_EN defined, mult/multu finish at t0+2.
module muldiv (
    input  logic        clk,
    input  logic        reset,
    input  logic        startE,
    input  logic [1:0]  opE,
    input  logic [31:0] srcaE,
    input  logic [31:0] srcbE,
    input  logic        mtE,
    input  logic        mtsel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic        neg_q_q, neg_q_d;
    logic        neg_r_q, neg_r_d;
    logic        dz_q, dz_d;
    logic [31:0] dvd_q, dvd_d;
    logic [31:0] b_q, b_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        accept, mt_wr, last_iter;
    logic        sgn_a, sgn_b;
    logic [31:0] a_mag, b_mag;
    logic [32:0] r33, sum33;
    logic [31:0] diff32, rem_n;
    logic        ge;
    logic [63:0] div_step, mul_step, step, res, prod;
    logic [31:0] quo_res, rem_res;

    assign accept = (state_q != RUN) && startE;
    assign mt_wr  = (state_q != RUN) && !startE && mtE;

`ifdef MULDIV_FAST_MULT_EN
    assign last_iter = op_q[1] ? (cnt_q == 5'd31) : 1'b1;
    assign res       = op_q[1] ? step : acc_q;
`else
    assign last_iter = (cnt_q == 5'd31);
    assign res       = step;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (startE) state_d = RUN;
            RUN:     if (last_iter) state_d = DONE;
            DONE:    state_d = startE ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    assign hi = hi_q;
    assign lo = lo_q;

    // Signed ops (op[0] == 0) work on magnitudes; signs are restored at completion.
    always_comb begin
        sgn_a = srcaE[31] & ~opE[0];
        sgn_b = srcbE[31] & ~opE[0];
        a_mag = sgn_a ? -srcaE : srcaE;
        b_mag = sgn_b ? -srcbE : srcbE;
    end

    always_comb begin
        r33      = acc_q[63:31];
        ge       = (r33 >= {1'b0, b_q});
        diff32   = r33[31:0] - b_q;
        rem_n    = ge ? diff32 : r33[31:0];
        div_step = {rem_n, acc_q[30:0], ge};
        sum33    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
        mul_step = {sum33, acc_q[31:1]};
        step     = op_q[1] ? div_step : mul_step;
    end

    always_comb begin
        prod    = neg_q_q ? -res : res;
        quo_res = neg_q_q ? -res[31:0] : res[31:0];
        rem_res = neg_r_q ? -res[63:32] : res[63:32];
    end

    always_comb begin
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        dz_d    = dz_q;
        dvd_d   = dvd_q;
        b_d     = b_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (accept) begin
            cnt_d   = 5'd0;
            op_d    = opE;
            neg_q_d = sgn_a ^ sgn_b;
            neg_r_d = sgn_a;
            dz_d    = (srcbE == 32'd0);
            dvd_d   = srcaE;
            b_d     = b_mag;
`ifdef MULDIV_FAST_MULT_EN
            acc_d   = opE[1] ? {32'd0, a_mag} : ({32'd0, a_mag} * {32'd0, b_mag});
`else
            acc_d   = {32'd0, a_mag};
`endif
        end else if (state_q == RUN) begin
            cnt_d = cnt_q + 5'd1;
            acc_d = step;
            if (last_iter) begin
                if (!op_q[1]) begin
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
                end else if (dz_q) begin
                    hi_d = dvd_q;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    hi_d = rem_res;
                    lo_d = quo_res;
                end
            end
        end else if (mt_wr) begin
            if (mtsel) hi_d = srcaE;
            else       lo_d = srcaE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= 5'd0;
            op_q    <= 2'd0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            dz_q    <= 1'b0;
            dvd_q   <= 32'd0;
            b_q     <= 32'd0;
            acc_q   <= 64'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
            dz_q    <= dz_d;
            dvd_q   <= dvd_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule
